// File: rtl/approx_adder_pkg.sv
// Shared types and helpers for the pipelined approximate adder.
// Holds the KW derivation, the LOA golden model and a saturating add.
package approx_adder_pkg;

    localparam int MAX_W = 32;

    function automatic int calc_kw(input int width);
        return $clog2(width + 1);
    endfunction

    // Lower-part-OR adder: k LSBs are a|b (cin folded into bit 0),
    // carry into the exact upper part is a[k-1]&b[k-1], or cin for k=0.
    // Operands must be zero-extended from their true width, k <= width.
    function automatic logic [MAX_W:0] loa_sum(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             cin,
        input int               k
    );
        logic [MAX_W:0] low;
        logic [MAX_W:0] upper;
        logic           c_up;
        low  = '0;
        c_up = cin;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < k) low[i] = a[i] | b[i];
        end
        if (k > 0) begin
            low[0] = low[0] | cin;
            c_up   = a[k-1] & b[k-1];
        end
        upper = {1'b0, a >> k} + {1'b0, b >> k}
              + {{MAX_W{1'b0}}, c_up};
        return (upper << k) | low;
    endfunction

    // acc + add clipped to the largest w-bit value.
    function automatic logic [MAX_W-1:0] sat_add(
        input logic [MAX_W-1:0] acc,
        input logic [MAX_W-1:0] add,
        input int               w
    );
        logic [MAX_W:0] s;
        logic [MAX_W:0] lim;
        s   = {1'b0, acc} + {1'b0, add};
        lim = ({{MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
        return (s > lim) ? lim[MAX_W-1:0] : s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/approx_adder_if.sv
// Operand/result valid-ready bundle for approx_adder_pipe.
// master = producer/consumer side, slave = the adder.
interface approx_adder_if
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int KW    = calc_kw(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [KW-1:0]    cfg_k;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_cin, cfg_k, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, cfg_k, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/approx_adder_pipe_monitor.sv
// approx_err_monitor: saturating mismatch count and |error| sum.
// Ports: clk, rst_n, clr, deliver, err, diff -> err_cnt, err_sum.
module approx_err_monitor
    import approx_adder_pkg::*;
#(
    parameter int DW    = 6,
    parameter int ERR_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             deliver,
    input  logic             err,
    input  logic [DW-1:0]    diff,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ERR_W-1:0] err_sum
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_sum <= '0;
        end else if (clr) begin
            // clear beats a same-cycle delivery
            err_cnt <= '0;
            err_sum <= '0;
        end else if (deliver) begin
            err_cnt <= CNT_W'(sat_add(MAX_W'(err_cnt), MAX_W'(err), CNT_W));
            err_sum <= ERR_W'(sat_add(MAX_W'(err_sum), MAX_W'(diff), ERR_W));
        end
    end
endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined LOA adder with per-transaction k and error monitor.
// Ports: clk, rst_n, bus (operands/result), err_clr, err_cnt, err_sum.
module approx_adder_pipe
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int ERR_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    approx_adder_if.slave    bus,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ERR_W-1:0] err_sum
);
    localparam int KW = calc_kw(WIDTH);

    logic             en;
    logic             deliver;
    logic [KW-1:0]    k_in;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [KW-1:0]    s1_k;

    logic [WIDTH:0]   approx;
    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   s2_diff;

    // global stall: both stages move together
    assign en          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;
    assign deliver     = bus.out_valid & bus.out_ready;

    assign k_in = (bus.cfg_k > KW'(WIDTH)) ? KW'(WIDTH) : bus.cfg_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_k     <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a   <= bus.in_a;
                s1_b   <= bus.in_b;
                s1_cin <= bus.in_cin;
                s1_k   <= k_in;
            end
        end
    end

    always_comb begin
        approx = (WIDTH+1)'(loa_sum(MAX_W'(s1_a), MAX_W'(s1_b),
                                    s1_cin, int'(s1_k)));
        exact  = {1'b0, s1_a} + {1'b0, s1_b} + (WIDTH+1)'(s1_cin);
        diff   = (exact >= approx) ? exact - approx : approx - exact;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_err   <= 1'b0;
            s2_diff       <= '0;
        end else if (en) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_sum <= approx;
                bus.out_err <= (approx != exact);
                s2_diff     <= diff;
            end
        end
    end

    approx_err_monitor #(
        .DW    (WIDTH + 1),
        .ERR_W (ERR_W),
        .CNT_W (CNT_W)
    ) u_mon (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (err_clr),
        .deliver (deliver),
        .err     (bus.out_err),
        .diff    (s2_diff),
        .err_cnt (err_cnt),
        .err_sum (err_sum)
    );
endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed checks of approx_adder_pipe (WIDTH=5, ERR_W=4) plus a
// randomised WIDTH=8 run against an independent LOA formula.
module tb_approx_adder_pipe;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr5  = 1'b0;
    logic        clr8  = 1'b0;
    logic [15:0] cnt5;
    logic [3:0]  sum5;
    logic [15:0] cnt8;
    logic [15:0] sum8;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    approx_adder_if #(.WIDTH(5)) b5 ();
    approx_adder_if #(.WIDTH(8)) b8 ();

    approx_adder_pipe #(.WIDTH(5), .ERR_W(4), .CNT_W(16)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(b5),
        .err_clr(clr5), .err_cnt(cnt5), .err_sum(sum5)
    );

    approx_adder_pipe #(.WIDTH(8), .ERR_W(16), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8),
        .err_clr(clr8), .err_cnt(cnt8), .err_sum(sum8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive5(input logic v, input int a, input int b,
                          input logic cin, input int k);
        b5.in_valid = v;
        b5.in_a     = 5'(a);
        b5.in_b     = 5'(b);
        b5.in_cin   = cin;
        b5.cfg_k    = 3'(k);
    endtask

    // {mismatch, approx sum} for WIDTH=8, written as masked exact adds
    function automatic logic [9:0] model8(input int a, input int b,
                                          input int cin, input int kr);
        int k, m, low, cup, up, s, ex;
        k   = (kr > 8) ? 8 : kr;
        m   = (1 << k) - 1;
        low = (a | b) & m;
        cup = cin;
        if (k > 0) begin
            low = low | cin;
            cup = (a >> (k - 1)) & (b >> (k - 1)) & 1;
        end
        up = (a & ~m) + (b & ~m) + (cup << k);
        s  = up | low;
        ex = a + b + cin;
        return {(s != ex), 9'(s)};
    endfunction

    initial begin
        logic [9:0] q[$];
        logic [9:0] exp10;
        int got;
        int cyc;
        int ra, rb, rc, rk;

        drive5(0, 0, 0, 0, 0);
        b5.out_ready = 1'b0;
        b8.in_valid = 1'b0; b8.in_a = '0; b8.in_b = '0;
        b8.in_cin = 1'b0; b8.cfg_k = '0; b8.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", b5.out_valid, 0);
        chk("rst_out_sum", b5.out_sum, 0);
        chk("rst_out_err", b5.out_err, 0);
        chk("rst_err_cnt", cnt5, 0);
        chk("rst_err_sum", sum5, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // exact path, latency 2
        b5.out_ready = 1'b1;
        drive5(1, 22, 11, 0, 0);
        chk("t1_in_ready", b5.in_ready, 1);
        tick;
        b5.in_valid = 1'b0;
        chk("t1_lat1_valid", b5.out_valid, 0);
        tick;
        chk("t1_valid", b5.out_valid, 1);
        chk("t1_sum", b5.out_sum, 33);
        chk("t1_err", b5.out_err, 0);
        tick;
        chk("t1_err_sum", sum5, 0);
        chk("t1_err_cnt", cnt5, 0);
        chk("t1_drained", b5.out_valid, 0);

        // k=2 approximation
        drive5(1, 22, 11, 0, 2);
        tick;
        b5.in_valid = 1'b0;
        tick;
        chk("t2_sum", b5.out_sum, 35);
        chk("t2_err", b5.out_err, 1);
        tick;
        chk("t2_err_cnt", cnt5, 1);
        chk("t2_err_sum", sum5, 2);

        // backpressure
        b5.out_ready = 1'b0;
        drive5(1, 1, 2, 0, 0);
        tick;
        drive5(1, 3, 4, 0, 0);
        tick;
        drive5(1, 5, 6, 0, 0);
        repeat (5) begin
            chk("t3_in_ready_low", b5.in_ready, 0);
            chk("t3_sum_held", b5.out_sum, 3);
            tick;
        end
        b5.out_ready = 1'b1;
        tick;
        b5.in_valid = 1'b0;
        chk("t3_r1_valid", b5.out_valid, 1);
        chk("t3_r1_sum", b5.out_sum, 7);
        tick;
        chk("t3_r2_sum", b5.out_sum, 11);
        tick;
        chk("t3_no_dup", b5.out_valid, 0);

        // cfg_k captured at accept
        drive5(1, 31, 31, 1, 0);
        tick;
        drive5(1, 5, 3, 0, 3);
        tick;
        b5.in_valid = 1'b0;
        chk("t4_sum_exact", b5.out_sum, 63);
        chk("t4_err_exact", b5.out_err, 0);
        tick;
        chk("t4_sum_k3", b5.out_sum, 7);
        chk("t4_err_k3", b5.out_err, 1);
        tick;

        // k above WIDTH clamps to WIDTH
        drive5(1, 22, 11, 0, 7);
        tick;
        b5.in_valid = 1'b0;
        tick;
        chk("clamp_sum", b5.out_sum, 31);
        chk("clamp_err", b5.out_err, 1);
        tick;
        chk("clamp_err_cnt", cnt5, 3);
        chk("clamp_err_sum", sum5, 5);

        // saturation and clear priority
        clr5 = 1'b1;
        tick;
        clr5 = 1'b0;
        chk("t5_clr_cnt", cnt5, 0);
        chk("t5_clr_sum", sum5, 0);
        drive5(1, 22, 11, 0, 2);
        repeat (8) tick;
        b5.in_valid = 1'b0;
        repeat (2) tick;
        chk("t5_sat_cnt", cnt5, 8);
        chk("t5_sat_sum", sum5, 15);
        drive5(1, 22, 11, 0, 2);
        tick;
        b5.in_valid = 1'b0;
        tick;
        clr5 = 1'b1;
        tick;
        clr5 = 1'b0;
        chk("t5_clr_win_cnt", cnt5, 0);
        chk("t5_clr_win_sum", sum5, 0);
        chk("t5_clr_drained", b5.out_valid, 0);

        // async reset with two in flight
        drive5(1, 22, 11, 0, 2);
        tick;
        b5.in_valid = 1'b0;
        repeat (2) tick;
        chk("t6_pre_cnt", cnt5, 1);
        b5.out_ready = 1'b0;
        drive5(1, 1, 2, 0, 0);
        tick;
        drive5(1, 3, 4, 0, 0);
        tick;
        b5.in_valid = 1'b0;
        chk("t6_pre_valid", b5.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", b5.out_valid, 0);
        chk("t6_rst_cnt", cnt5, 0);
        chk("t6_rst_sum", sum5, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        b5.out_ready = 1'b1;
        repeat (3) begin
            tick;
            chk("t6_no_pulse", b5.out_valid, 0);
        end

        // random WIDTH=8 with stalls
        got = 0;
        cyc = 0;
        while (got < 2000 && cyc < 20000) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            rc = int'($urandom_range(0, 1));
            rk = int'($urandom_range(0, 15));
            b8.in_valid  = ($urandom_range(0, 3) != 0);
            b8.in_a      = 8'(ra);
            b8.in_b      = 8'(rb);
            b8.in_cin    = 1'(rc);
            b8.cfg_k     = 4'(rk);
            b8.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b8.out_valid && b8.out_ready) begin
                exp10 = (q.size() > 0) ? q.pop_front() : 10'h3ff;
                chk("rnd_sum", 32'(b8.out_sum), 32'(exp10[8:0]));
                chk("rnd_err", 32'(b8.out_err), 32'(exp10[9]));
                got++;
            end
            if (b8.in_valid && b8.in_ready)
                q.push_back(model8(ra, rb, rc, rk));
            tick;
            cyc++;
        end
        b8.in_valid = 1'b0;
        chk("rnd_delivered", got, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
